// File: rtl/signed_div_ctrl.sv
// Signed WIDTH-bit restoring divider controller; SIGNED_DIV_ZERO_DETECT_EN adds a one-cycle divide-by-zero path.
// Result WIDTH+1 edges after an accepted start; start is ignored (not queued) while busy.
module signed_div_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic            sq, sr;
  logic [WIDTH-1:0] a_sh, b_mag, r_acc, q_mag;
  logic [WIDTH:0]  r_shift, r_diff;
  logic            q_bit;

  // r_shift < 2^WIDTH and b_mag <= 2^(WIDTH-1), so the borrow out of the
  // WIDTH+1-bit subtraction is exactly the "R < |divisor|" comparison.
  always_comb begin
    r_shift = {r_acc, a_sh[WIDTH-1]};
    r_diff  = r_shift - {1'b0, b_mag};
    q_bit   = ~r_diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SIGNED_DIV_ZERO_DETECT_EN
          if (divisor != '0) state_nxt = ITER;
`else
          state_nxt = ITER;
`endif
        end
      end
      ITER: begin
        busy = 1'b1;
        if (count == LAST) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SIGNED_DIV_ZERO_DETECT_EN
  logic dz_q;
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      a_sh      <= '0;
      b_mag     <= '0;
      r_acc     <= '0;
      q_mag     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
`ifdef SIGNED_DIV_ZERO_DETECT_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sq    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sr    <= dividend[WIDTH-1];
            a_sh  <= dividend[WIDTH-1] ? -dividend : dividend;
            b_mag <= divisor[WIDTH-1] ? -divisor : divisor;
            r_acc <= '0;
            q_mag <= '0;
            count <= '0;
`ifdef SIGNED_DIV_ZERO_DETECT_EN
            dz_q  <= 1'b0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dz_q      <= 1'b1;
              done      <= 1'b1;
            end
`endif
          end
        end
        ITER: begin
          a_sh  <= a_sh << 1;
          r_acc <= q_bit ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
          q_mag <= {q_mag[WIDTH-2:0], q_bit};
          count <= count + CW'(1);
        end
        FIX: begin
          quotient  <= sq ? -q_mag : q_mag;
          remainder <= sr ? -r_acc : r_acc;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
